updown_counter_n: RTL and testbench
===================================

Name: updown_counter_n

Overview:
Parametrised up/down counter, the next generation of the team's fixed 8-bit down counter. It adds programmable width, a runtime terminal limit, synchronous load, count enable and direction. It supports three count modes (wrap, saturate, one-shot) and produces a terminal-count pulse. It is the standard tick/timeout source for timers and sequencers in the design.

Parameters:
WIDTH, 8, counter width in bits (legal range 2..32)
RESET_VAL, all ones ({WIDTH{1'b1}}), value loaded into data by start

Ports:
clock  in  1  single clock; all state changes on its rising edge
start  in  1  reset, asynchronous and active-high; loads RESET_VAL and clears all flags and state
en  in  1  count enable; one step per clock while high
up_dn  in  1  direction: 1 = increment, 0 = decrement
load  in  1  synchronous load of load_val
load_val  in  WIDTH  value to load
limit  in  WIDTH  terminal value for up counting; counting range is 0..limit
mode  in  2  00 = wrap, 01 = saturate, 10 = one-shot, 11 = reserved (behaves as wrap)
data  out  WIDTH  current count (registered)
tc  out  1  terminal-count pulse (registered, one cycle)
done  out  1  one-shot finished (registered, level)

Behaviour:
- start=1, asynchronously: data=RESET_VAL, tc=0, done=0, FSM=RUN. The output change does not wait for the next edge.
- Priority per edge: start > load > en. If load and en are both high, load wins and no step occurs.
- Load: data = min(load_val, limit); tc=0; done=0; FSM=RUN. Takes effect in the same edge; data shows the new value the next cycle.
- Terminal value: term = limit when up_dn=1, term = 0 when up_dn=0.
- Step (en=1, no load, FSM=RUN), data <= limit:
  - data != term: data ± 1.
  - data == term, wrap mode: up goes to 0, down goes to limit; tc=1 for that cycle.
  - data == term, saturate mode: data holds; tc=0.
  - data == term, one-shot mode: data holds; tc=0.
- Reaching term: a step that moves data onto term sets tc=1 in the same cycle data becomes term, in saturate and one-shot modes. In one-shot mode it also sets FSM to DONE and done=1.
- Out of range (data > limit, e.g. after reset or a limit change): the next step loads 0 (up) or limit (down). tc=0 on that step.
- FSM states are RUN and DONE.
  - RUN to DONE: one-shot step reaches term.
  - DONE to RUN: load or start only.
  - In DONE, en is ignored and data holds.
- Mode and direction changes take effect on the next edge and do not clear done.
- tc is never high for two consecutive cycles, except in wrap mode with limit=0, where every step wraps and tc stays high while en=1.
- All arithmetic is modulo 2^WIDTH; no carry-out port. With limit=0, data stays 0.
- en=0: data, done and FSM hold; tc=0.

Decomposition:
- Shared package counter_pkg holds:
  - mode encodings: MODE_WRAP, MODE_SAT, MODE_ONESHOT
  - FSM state typedef: ST_RUN, ST_DONE
- One combinational sub-module, cnt_next_val. Inputs: data, limit, up_dn, mode. Outputs: next value, hit_term and at_term flags.
- The top module holds the registers, the priority logic and the FSM.

Test Plan:
- Reset and count down: WIDTH=8, limit=8'hFF, start pulse, then en=1, up_dn=0, mode=wrap. Data reads FF, FE, FD, …, 00, FF. tc is high exactly in the cycle data returns to FF.
- Start asserted mid-count: at data=8'h37, assert start between edges. data=FF immediately, before the next edge; tc=0 and done=0.
- Up with limit and wrap: load 8'h03, limit=8'h05, up_dn=1, wrap mode. Data reads 03, 04, 05, 00, 01. tc is high in the cycle data=00.
- Saturate: limit=8'h0A, load 8'h08, up, sat mode. Data reads 08, 09, 0A, 0A, 0A. tc is high only on the first 0A.
- One-shot and re-arm: load 8'h02, down, one-shot mode. Data reads 02, 01, 00; done=1 and stays 1 with en=1. Load 8'h04: done=0 and counting resumes 04, 03.
- Priority and clamp: load=1 and en=1 with load_val=8'h20 and limit=8'h10 gives data=10 with no step. Then lower limit to 8'h08 and step down: data=08, tc=0.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared encodings for the up/down counter family.
// Mode selects the terminal-value behaviour; the FSM only distinguishes RUN and DONE.
package counter_pkg;

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  typedef logic [0:0] state_t;
  localparam state_t ST_RUN  = 1'b0;
  localparam state_t ST_DONE = 1'b1;

endpackage

// File: rtl/cnt_next_val.sv
// Combinational next-count for one enabled step: wrap/saturate/clamp resolution.
// Zero latency; no flow control.
module cnt_next_val
  import counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] limit,
  input  logic             up_dn,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] next_val,
  output logic             hit_term,
  output logic             at_term
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] wrap_val;
  logic [WIDTH-1:0] stepped;
  logic             wrap_mode;
  logic             in_range;

  assign term      = up_dn ? limit : '0;
  assign wrap_val  = up_dn ? '0 : limit;
  assign stepped   = up_dn ? data + ONE : data - ONE;
  // Reserved mode 11 falls through to wrap behaviour.
  assign wrap_mode = (mode != MODE_SAT) && (mode != MODE_ONESHOT);
  assign in_range  = (data <= limit);
  assign at_term   = in_range && (data == term);
  assign hit_term  = in_range && !at_term && (stepped == term);

  always_comb begin
    next_val = data;
    if (!in_range) begin
      next_val = wrap_val;
    end else if (at_term) begin
      next_val = wrap_mode ? wrap_val : data;
    end else begin
      next_val = stepped;
    end
  end

endmodule

// File: rtl/updown_counter_n.sv
// Parametrised up/down counter with load, limit, wrap/saturate/one-shot modes and tc pulse.
// Outputs registered, one clock after the controlling inputs; start resets asynchronously.
module updown_counter_n
  import counter_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}}
) (
  input  logic             clock,
  input  logic             start,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] data,
  output logic             tc,
  output logic             done
);

  state_t           state;
  logic [WIDTH-1:0] next_val;
  logic             hit_term;
  logic             at_term;
  logic             wrap_mode;
  logic             oneshot_mode;

  cnt_next_val #(
    .WIDTH (WIDTH)
  ) u_next (
    .data     (data),
    .limit    (limit),
    .up_dn    (up_dn),
    .mode     (mode),
    .next_val (next_val),
    .hit_term (hit_term),
    .at_term  (at_term)
  );

  assign wrap_mode    = (mode != MODE_SAT) && (mode != MODE_ONESHOT);
  assign oneshot_mode = (mode == MODE_ONESHOT);

  always_ff @(posedge clock or posedge start) begin
    if (start) begin
      data  <= RESET_VAL;
      tc    <= 1'b0;
      state <= ST_RUN;
    end else if (load) begin
      data  <= (load_val > limit) ? limit : load_val;
      tc    <= 1'b0;
      state <= ST_RUN;
    end else if (en && (state == ST_RUN)) begin
      data <= next_val;
      // Wrap pulses on the wrap-around itself; sat/one-shot pulse on arrival at term.
      tc   <= wrap_mode ? at_term : hit_term;
      if (oneshot_mode && hit_term) begin
        state <= ST_DONE;
      end
    end else begin
      tc <= 1'b0;
    end
  end

  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_updown_counter_n.sv
// Bench for updown_counter_n: directed scenarios with literal expectations,
// then randomized traffic, all outputs checked every cycle against a behavioural model.
module tb_updown_counter_n;

  logic       clock = 1'b0;
  logic       start;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] limit;
  logic [1:0] mode;
  logic [7:0] data;
  logic       tc;
  logic       done;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  int m_data;
  int m_tc;
  int m_done;
  int m_term;

  updown_counter_n #(.WIDTH(8)) dut (
    .clock    (clock),
    .start    (start),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .limit    (limit),
    .mode     (mode),
    .data     (data),
    .tc       (tc),
    .done     (done)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect3(input string name, input int d, input int t, input int dn);
    check({name, ".data"}, int'(data), d);
    check({name, ".tc"},   int'(tc),   t);
    check({name, ".done"}, int'(done), dn);
  endtask

  // Reference: counting range 0..limit, term depends on direction, priority start > load > en.
  always @(posedge clock or posedge start) begin
    if (start) begin
      m_data = 255; m_tc = 0; m_done = 0;
    end else if (load) begin
      m_data = (int'(load_val) > int'(limit)) ? int'(limit) : int'(load_val);
      m_tc = 0; m_done = 0;
    end else if (en && m_done == 0) begin
      m_term = up_dn ? int'(limit) : 0;
      if (m_data > int'(limit)) begin
        m_data = up_dn ? 0 : int'(limit);
        m_tc = 0;
      end else if (m_data == m_term) begin
        if (mode == 2'b01 || mode == 2'b10) begin
          m_tc = 0;
        end else begin
          m_data = up_dn ? 0 : int'(limit);
          m_tc = 1;
        end
      end else begin
        m_data = up_dn ? m_data + 1 : m_data - 1;
        m_tc = (m_data == m_term && (mode == 2'b01 || mode == 2'b10)) ? 1 : 0;
        if (m_data == m_term && mode == 2'b10) m_done = 1;
      end
    end else begin
      m_tc = 0;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("model.data", int'(data), m_data);
      check("model.tc",   int'(tc),   m_tc);
      check("model.done", int'(done), m_done);
    end
  end

  task automatic step(input logic s, input logic l, input logic e, input logic u,
                      input logic [7:0] lv, input logic [7:0] lim, input logic [1:0] md);
    #1;
    start = s; load = l; en = e; up_dn = u; load_val = lv; limit = lim; mode = md;
    @(negedge clock);
  endtask

  int tc_seen;
  logic [7:0] r_lim;
  logic [1:0] r_mode;
  logic       r_up;

  initial begin
    start = 1'b1; en = 1'b0; up_dn = 1'b0; load = 1'b0;
    load_val = 8'h00; limit = 8'hFF; mode = 2'b00;
    repeat (2) @(negedge clock);
    chk_en = 1'b1;
    step(0, 0, 0, 0, 8'h00, 8'hFF, 2'b00);
    expect3("reset", 8'hFF, 0, 0);

    // Full down sweep in wrap mode: one tc, on the return to FF.
    tc_seen = 0;
    for (int k = 1; k <= 256; k++) begin
      step(0, 0, 1, 0, 8'h00, 8'hFF, 2'b00);
      if (tc) tc_seen++;
      if (k == 1)   expect3("down1", 8'hFE, 0, 0);
      if (k == 255) expect3("down255", 8'h00, 0, 0);
      if (k == 256) expect3("down_wrap", 8'hFF, 1, 0);
    end
    check("down_tc_count", tc_seen, 1);

    // Start asserted between edges takes effect immediately.
    step(0, 1, 0, 0, 8'h37, 8'hFF, 2'b00);
    expect3("ld37", 8'h37, 0, 0);
    #2; start = 1'b1; load = 1'b0; en = 1'b0;
    #1; expect3("async_start", 8'hFF, 0, 0);
    #1; start = 1'b0;
    @(negedge clock);

    // Up with limit, wrap.
    step(0, 1, 0, 1, 8'h03, 8'h05, 2'b00); expect3("upw_ld", 8'h03, 0, 0);
    step(0, 0, 1, 1, 8'h00, 8'h05, 2'b00); expect3("upw1", 8'h04, 0, 0);
    step(0, 0, 1, 1, 8'h00, 8'h05, 2'b00); expect3("upw2", 8'h05, 0, 0);
    step(0, 0, 1, 1, 8'h00, 8'h05, 2'b00); expect3("upw3", 8'h00, 1, 0);
    step(0, 0, 1, 1, 8'h00, 8'h05, 2'b00); expect3("upw4", 8'h01, 0, 0);

    // Saturate.
    step(0, 1, 0, 1, 8'h08, 8'h0A, 2'b01); expect3("sat_ld", 8'h08, 0, 0);
    step(0, 0, 1, 1, 8'h00, 8'h0A, 2'b01); expect3("sat1", 8'h09, 0, 0);
    step(0, 0, 1, 1, 8'h00, 8'h0A, 2'b01); expect3("sat2", 8'h0A, 1, 0);
    step(0, 0, 1, 1, 8'h00, 8'h0A, 2'b01); expect3("sat3", 8'h0A, 0, 0);
    step(0, 0, 1, 1, 8'h00, 8'h0A, 2'b01); expect3("sat4", 8'h0A, 0, 0);

    // One-shot, mode change while done, re-arm by load.
    step(0, 1, 0, 0, 8'h02, 8'h0A, 2'b10); expect3("os_ld", 8'h02, 0, 0);
    step(0, 0, 1, 0, 8'h00, 8'h0A, 2'b10); expect3("os1", 8'h01, 0, 0);
    step(0, 0, 1, 0, 8'h00, 8'h0A, 2'b10); expect3("os2", 8'h00, 1, 1);
    step(0, 0, 1, 0, 8'h00, 8'h0A, 2'b10); expect3("os_hold", 8'h00, 0, 1);
    step(0, 0, 1, 0, 8'h00, 8'h0A, 2'b00); expect3("os_modechg", 8'h00, 0, 1);
    step(0, 1, 0, 0, 8'h04, 8'h0A, 2'b10); expect3("os_rearm", 8'h04, 0, 0);
    step(0, 0, 1, 0, 8'h00, 8'h0A, 2'b10); expect3("os_resume", 8'h03, 0, 0);

    // Load beats enable and is clamped; out-of-range step down lands on limit.
    step(0, 1, 1, 0, 8'h20, 8'h10, 2'b00); expect3("clamp", 8'h10, 0, 0);
    step(0, 0, 1, 0, 8'h00, 8'h08, 2'b00); expect3("oor_down", 8'h08, 0, 0);

    // limit=0 in wrap: tc held high while enabled.
    step(0, 1, 0, 1, 8'h00, 8'h00, 2'b00); expect3("lim0_ld", 8'h00, 0, 0);
    step(0, 0, 1, 1, 8'h00, 8'h00, 2'b00); expect3("lim0_a", 8'h00, 1, 0);
    step(0, 0, 1, 1, 8'h00, 8'h00, 2'b00); expect3("lim0_b", 8'h00, 1, 0);
    step(0, 0, 0, 1, 8'h00, 8'h00, 2'b00); expect3("lim0_idle", 8'h00, 0, 0);

    // Randomized traffic with small limits so terminal values are hit often.
    r_lim = 8'd9; r_mode = 2'b00; r_up = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0)
        r_lim = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12));
      if ($urandom_range(0, 15) == 0) r_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) r_up = 1'($urandom_range(0, 1));
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 9) < 8),
           r_up,
           ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 14)),
           r_lim, r_mode);
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
